key_mode_ctrl: RTL and testbench

Front-panel input stage for the clock/calendar timekeeper. It debounces four raw push-buttons and maintains the 4-bit adjust-mode code `flag`. It also produces single-cycle increment/decrement pulses with hold-to-repeat. `flag`, `key2_pulse` and `key3_pulse` drive the timekeeper's `flag`, `key2` and `key3` inputs directly.

---
 rtl/panel_pkg.sv | 18 +
 rtl/key_debounce.sv | 37 +++
 rtl/key_mode_ctrl.sv | 71 +++++++
 tb/tb_key_mode_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/panel_pkg.sv
// panel_pkg: mode codes shared by the front-panel input stage and the timekeeper
//   exports MODE_* encodings of the 4-bit flag and next_mode() for the key1 advance
package panel_pkg;
  localparam logic [3:0] MODE_RUN   = 4'd0;
  localparam logic [3:0] MODE_PAUSE = 4'd1;
  localparam logic [3:0] MODE_YEAR  = 4'd2;
  localparam logic [3:0] MODE_MONTH = 4'd3;
  localparam logic [3:0] MODE_DAY   = 4'd4;
  localparam logic [3:0] MODE_WEEK  = 4'd5;
  localparam logic [3:0] MODE_HOUR  = 4'd6;
  localparam logic [3:0] MODE_MIN   = 4'd7;
  localparam logic [3:0] MODE_SEC   = 4'd8;
  localparam logic [3:0] MODE_LAST  = MODE_SEC;

  function automatic logic [3:0] next_mode(input logic [3:0] f);
    return (f <= MODE_PAUSE) ? MODE_YEAR : (f == MODE_LAST) ? MODE_RUN : f + 4'd1;
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-FF synchronizer + stability counter for one active-low raw key
//   ports: clk, rst (async, active-high), key_n (raw, async),
//          pressed (debounced level, 1 = held), press_evt (1-cycle pulse on press)
module key_debounce import panel_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic pressed,
  output logic press_evt
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1_q, s2_q, deb_q, deb_d, evt_q, hit;
  logic [CW-1:0] cnt_q, cnt_d;
  // the debounced state flips on the cycle the count would reach DEBOUNCE_CYCLES
  assign hit   = (s2_q != deb_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
  assign deb_d = hit ? s2_q : deb_q;
  assign cnt_d = (s2_q == deb_q || hit) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q  <= 1'b1;
      s2_q  <= 1'b1;
      deb_q <= 1'b1;
      cnt_q <= '0;
      evt_q <= 1'b0;
    end else begin
      s1_q  <= key_n;
      s2_q  <= s1_q;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
      evt_q <= deb_q & ~deb_d;
    end
  end
  assign pressed   = ~deb_q;
  assign press_evt = evt_q;
endmodule

// File: rtl/key_mode_ctrl.sv
// key_mode_ctrl: debounced front panel -> adjust-mode flag and inc/dec pulses with hold-to-repeat
//   ports: clk, rst (async, active-high), key0_n..key3_n (raw active-low buttons),
//          flag (mode code), key2_pulse / key3_pulse (one-cycle inc/dec requests)
module key_mode_ctrl import panel_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key0_n,
  input  logic       key1_n,
  input  logic       key2_n,
  input  logic       key3_n,
  output logic [3:0] flag,
  output logic       key2_pulse,
  output logic       key3_pulse
);
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  logic [3:0] keys_n, pressed, evt;
  logic [3:0] flag_q, flag_d;
  logic       k2_q, k2_d, k3_q, k3_d, run_q, run_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic       mode_chg, in_adj, one, fire, unused;

  assign keys_n = {key3_n, key2_n, key1_n, key0_n};
  for (genvar g = 0; g < 4; g++) begin : g_deb
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk(clk), .rst(rst), .key_n(keys_n[g]), .pressed(pressed[g]), .press_evt(evt[g])
    );
  end
  assign unused = ^pressed[1:0];

  // key1 is checked before key0 so it wins a same-cycle tie
  assign flag_d = (flag_q > MODE_LAST) ? MODE_RUN :
                  evt[1] ? next_mode(flag_q) :
                  (evt[0] && flag_q <= MODE_PAUSE) ? (flag_q ^ 4'd1) : flag_q;
  assign mode_chg = flag_d != flag_q;
  assign in_adj   = (flag_q >= MODE_YEAR) && (flag_q <= MODE_LAST) && !mode_chg;
  // exactly one of key2/key3 held: both held is a conflict that blocks all pulses
  assign one  = pressed[2] ^ pressed[3];
  assign fire = run_q && one && (rcnt_q == RW'(REPEAT_DELAY - 1));
  // after a repeat pulse the counter is rewound so the next one lands REPEAT_PERIOD later
  assign rcnt_d = (mode_chg || !one || evt[2] || evt[3]) ? '0 :
                  fire ? RW'(REPEAT_DELAY - REPEAT_PERIOD) :
                  run_q ? rcnt_q + 1'b1 : '0;
  assign run_d = (mode_chg || !(pressed[2] || pressed[3])) ? 1'b0 :
                 ((evt[2] || evt[3]) && in_adj) ? 1'b1 : run_q;
  assign k2_d = in_adj && pressed[2] && !pressed[3] && (evt[2] || fire);
  assign k3_d = in_adj && pressed[3] && !pressed[2] && (evt[3] || fire);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q <= MODE_RUN;
      k2_q   <= 1'b0;
      k3_q   <= 1'b0;
      run_q  <= 1'b0;
      rcnt_q <= '0;
    end else begin
      flag_q <= flag_d;
      k2_q   <= k2_d;
      k3_q   <= k3_d;
      run_q  <= run_d;
      rcnt_q <= rcnt_d;
    end
  end

  assign flag       = flag_q;
  assign key2_pulse = k2_q;
  assign key3_pulse = k3_q;
endmodule

// File: tb/tb_key_mode_ctrl.sv
// tb_key_mode_ctrl: directed scenarios for key_mode_ctrl with DEBOUNCE=4, DELAY=20, PERIOD=5
module tb_key_mode_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic key0_n = 1'b1, key1_n = 1'b1, key2_n = 1'b1, key3_n = 1'b1;
  logic [3:0] flag;
  logic key2_pulse, key3_pulse;
  int errors = 0, checks = 0, cyc = 0, both_cnt = 0;
  int q2[$], q3[$];

  key_mode_ctrl #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)) dut (
    .clk(clk), .rst(rst), .key0_n(key0_n), .key1_n(key1_n), .key2_n(key2_n), .key3_n(key3_n),
    .flag(flag), .key2_pulse(key2_pulse), .key3_pulse(key3_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (key2_pulse) q2.push_back(cyc);
    if (key3_pulse) q3.push_back(cyc);
    if (key2_pulse && key3_pulse) both_cnt++;
  end

  task automatic set_key(input int k, input logic v);
    case (k)
      0: key0_n = v;
      1: key1_n = v;
      2: key2_n = v;
      default: key3_n = v;
    endcase
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int k, input int hold);
    set_key(k, 1'b0);
    cycles(hold);
    set_key(k, 1'b1);
    cycles(12);
  endtask

  task automatic apply_reset;
    key0_n = 1; key1_n = 1; key2_n = 1; key3_n = 1;
    rst = 1;
    cycles(3);
    rst = 0;
    cycles(2);
  endtask

  task automatic test_reset;
    cycles(3);
    checks++; if (flag !== 4'd0) begin errors++; $display("FAIL reset_flag: got %0d want 0", flag); end
    checks++; if (key2_pulse !== 1'b0) begin errors++; $display("FAIL reset_k2: got %b want 0", key2_pulse); end
    checks++; if (key3_pulse !== 1'b0) begin errors++; $display("FAIL reset_k3: got %b want 0", key3_pulse); end
    rst = 0;
    cycles(2);
  endtask

  task automatic test_bounce;
    key1_n = 0;
    cycles(3);
    key1_n = 1;
    cycles(15);
    checks++; if (flag !== 4'd0) begin errors++; $display("FAIL bounce_glitch: got %0d want 0", flag); end
    key1_n = 0;
    cycles(6);
    checks++; if (flag !== 4'd0) begin errors++; $display("FAIL bounce_early: got %0d want 0", flag); end
    cycles(1);
    checks++; if (flag !== 4'd2) begin errors++; $display("FAIL bounce_latency: got %0d want 2", flag); end
    cycles(3);
    key1_n = 1;
    cycles(12);
  endtask

  task automatic test_mode_cycle;
    logic [3:0] exp [9] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd0, 4'd2};
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      press(1, 10);
      checks++; if (flag !== exp[i]) begin errors++; $display("FAIL mode_cycle[%0d]: got %0d want %0d", i, flag, exp[i]); end
    end
  endtask

  task automatic test_pause;
    apply_reset();
    press(0, 10);
    checks++; if (flag !== 4'd1) begin errors++; $display("FAIL pause_on: got %0d want 1", flag); end
    press(0, 10);
    checks++; if (flag !== 4'd0) begin errors++; $display("FAIL pause_off: got %0d want 0", flag); end
    press(0, 10);
    q2.delete();
    press(2, 10);
    checks++; if (q2.size() !== 0) begin errors++; $display("FAIL pause_gate: got %0d pulses want 0", q2.size()); end
    checks++; if (flag !== 4'd1) begin errors++; $display("FAIL pause_hold: got %0d want 1", flag); end
    press(0, 10);
    key0_n = 0; key1_n = 0;
    cycles(10);
    key0_n = 1; key1_n = 1;
    cycles(12);
    checks++; if (flag !== 4'd2) begin errors++; $display("FAIL key1_priority: got %0d want 2", flag); end
  endtask

  task automatic test_repeat;
    int c0;
    int exp [7] = '{7, 27, 32, 37, 42, 47, 52};
    apply_reset();
    for (int i = 0; i < 5; i++) press(1, 10);
    checks++; if (flag !== 4'd6) begin errors++; $display("FAIL rep_setup: got %0d want 6", flag); end
    q2.delete(); q3.delete();
    c0 = cyc;
    key2_n = 0;
    cycles(50);
    key2_n = 1;
    cycles(25);
    checks++; if (q2.size() !== 7) begin errors++; $display("FAIL rep_count: got %0d want 7", q2.size()); end
    for (int i = 0; i < 7 && i < q2.size(); i++) begin
      checks++; if (q2[i] !== c0 + exp[i]) begin errors++; $display("FAIL rep_time[%0d]: got +%0d want +%0d", i, q2[i] - c0, exp[i]); end
    end
    checks++; if (q3.size() !== 0) begin errors++; $display("FAIL rep_k3: got %0d pulses want 0", q3.size()); end
  endtask

  task automatic test_conflict;
    int c0;
    apply_reset();
    press(1, 10);
    press(1, 10);
    q2.delete(); q3.delete();
    key2_n = 0; key3_n = 0;
    cycles(40);
    key2_n = 1; key3_n = 1;
    cycles(15);
    checks++; if (q2.size() !== 0) begin errors++; $display("FAIL conflict_k2: got %0d pulses want 0", q2.size()); end
    checks++; if (q3.size() !== 0) begin errors++; $display("FAIL conflict_k3: got %0d pulses want 0", q3.size()); end
    c0 = cyc;
    key3_n = 0;
    cycles(12);
    checks++; if (q3.size() !== 1) begin errors++; $display("FAIL dec_first: got %0d pulses want 1", q3.size()); end
    else begin
      checks++; if (q3[0] !== c0 + 7) begin errors++; $display("FAIL dec_time: got +%0d want +7", q3[0] - c0); end
    end
    key1_n = 0;
    cycles(10);
    key1_n = 1;
    cycles(40);
    key3_n = 1;
    cycles(12);
    checks++; if (flag !== 4'd4) begin errors++; $display("FAIL modechg_flag: got %0d want 4", flag); end
    checks++; if (q3.size() !== 1) begin errors++; $display("FAIL modechg_cancel: got %0d pulses want 1", q3.size()); end
    checks++; if (q2.size() !== 0) begin errors++; $display("FAIL modechg_k2: got %0d pulses want 0", q2.size()); end
  endtask

  task automatic test_async_reset;
    apply_reset();
    for (int i = 0; i < 6; i++) press(1, 10);
    checks++; if (flag !== 4'd7) begin errors++; $display("FAIL ar_setup: got %0d want 7", flag); end
    key2_n = 0;
    cycles(7);
    #1;
    checks++; if (key2_pulse !== 1'b1) begin errors++; $display("FAIL ar_pulse: got %b want 1", key2_pulse); end
    rst = 1;
    #1;
    checks++; if (flag !== 4'd0) begin errors++; $display("FAIL ar_flag: got %0d want 0", flag); end
    checks++; if (key2_pulse !== 1'b0) begin errors++; $display("FAIL ar_k2: got %b want 0", key2_pulse); end
    checks++; if (key3_pulse !== 1'b0) begin errors++; $display("FAIL ar_k3: got %b want 0", key3_pulse); end
    cycles(3);
    rst = 0;
    q2.delete();
    cycles(20);
    checks++; if (flag !== 4'd0) begin errors++; $display("FAIL ar_after_flag: got %0d want 0", flag); end
    checks++; if (q2.size() !== 0) begin errors++; $display("FAIL ar_after_pulse: got %0d pulses want 0", q2.size()); end
    key2_n = 1;
    cycles(12);
    press(1, 10);
    checks++; if (flag !== 4'd2) begin errors++; $display("FAIL ar_recover: got %0d want 2", flag); end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_mode_cycle();
    test_pause();
    test_repeat();
    test_conflict();
    test_async_reset();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL both_pulses: got %0d cycles want 0", both_cnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
